inst_boot_loader: RTL

Instruction-memory front end that sits directly upstream of the core's fetch port. After reset it receives a program as a little-endian byte stream over a valid/ready interface, writes it into an internal word-organised instruction memory, and holds the core in reset. It then releases the core and serves its fetch port (`ram_ce`/`ram_addr`/`ram_data`) with combinational reads.

---
 rtl/inst_boot_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/inst_boot_loader.sv
// rtl/inst_boot_loader.sv - byte-stream program loader and instruction memory for the core fetch port
module inst_boot_loader #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        core_rst,
  input  logic        ram_ce,
  input  logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        loading,
  output logic        overflow,
  output logic [31:0] words_loaded
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_LEN  = 2'd0,
    S_DATA = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_idx;
  logic [23:0] asm_reg;
  logic [31:0] n_reg;
  logic [31:0] word_full;
  logic [31:0] wl_inc;
  logic        accept;
  logic        last_byte;
  logic        in_range;
  logic        mem_we;
  logic [31:0] mem [0:DEPTH-1];

  // Address bits that do not select a word are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ram_addr[31:AW+2], ram_addr[1:0]};

  // Handshake and status outputs; reset forces the stream closed.
  assign in_ready  = !rst && (state != S_RUN);
  assign loading   = !rst && (state != S_RUN);
  assign accept    = in_valid && in_ready;
  assign last_byte = accept && (byte_idx == 2'd3);

  // Earlier bytes sit in asm_reg with byte 0 lowest; the incoming byte completes the word.
  assign word_full = {in_data, asm_reg};
  assign wl_inc    = words_loaded + 32'd1;
  assign in_range  = ((words_loaded >> AW) == 32'd0);
  assign mem_we    = last_byte && (state == S_DATA) && in_range;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LEN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: transitions only on the 4th byte of a word.
  always_comb begin
    state_next = state;
    if (last_byte) begin
      case (state)
        S_LEN: begin
          if (word_full == 32'd0) begin
            state_next = S_RUN;
          end else begin
            state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (wl_inc == n_reg) begin
            state_next = S_RUN;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Byte assembly, length capture, word counting, overflow and the delayed core reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx     <= 2'd0;
      asm_reg      <= 24'd0;
      n_reg        <= 32'd0;
      words_loaded <= 32'd0;
      overflow     <= 1'b0;
      core_rst     <= 1'b1;
    end else begin
      // Registered from state so the core sees one full RUN cycle before release.
      core_rst <= (state != S_RUN);
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        asm_reg  <= {in_data, asm_reg[23:8]};
        if (byte_idx == 2'd3) begin
          if (state == S_LEN) begin
            n_reg <= word_full;
          end else begin
            words_loaded <= wl_inc;
            if (!in_range) begin
              overflow <= 1'b1;
            end
          end
        end
      end
    end
  end

  // Instruction memory write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[words_loaded[AW-1:0]] <= word_full;
    end
  end

  // Combinational fetch, gated until the core is out of reset.
  always_comb begin
    ram_data = 32'h0;
    if (ram_ce && !core_rst) begin
      ram_data = mem[ram_addr[AW+1:2]];
    end
  end

endmodule
